// File: rtl/tcdm_slave_mem.sv
// -----------------------------------------------------------------------------
// tcdm_slave_mem
//
// Single-bank TCDM responder. NB_PORTS master ports are arbitrated round-robin
// onto one single-port word memory. The granted transaction is answered on the
// same port exactly one cycle after the grant. This is the TCDM model behind
// the HWPE benches, and it also serves as a scratch bank in small builds.
//
// Optional feature macro: TCDM_SLAVE_STALL_EN
//   Defined   : an 8-bit Fibonacci LFSR (taps 8,6,5,4) seeded with STALL_SEED
//               advances every non-reset cycle. While LFSR[0]=1 all grants
//               are withheld. This gives deterministic back-pressure.
//   Undefined : no LFSR is built, and any request is granted every cycle.
//
// Parameters
//   NB_PORTS   : number of master ports (>=1)
//   DATA_WIDTH : word width, fixed at 32 so that be_i maps onto 4 byte lanes
//   MEM_WORDS  : memory depth in words (power of 2, >=2)
//   STALL_SEED : non-zero LFSR reset value (used only with the stall macro)
//
// Ports
//   clk_i      : clock, rising edge
//   rst_i      : synchronous reset, active-high
//   req_i      : per-port request
//   gnt_o      : per-port grant, combinational from req_i and arbiter state
//   add_i      : per-port byte address (bits [1:0] are ignored)
//   wen_i      : per-port write enable, active-low (1=read, 0=write)
//   be_i       : per-port byte enables (write only)
//   data_i     : per-port write data
//   r_data_o   : per-port response data (read data, or 0 for writes)
//   r_valid_o  : per-port response valid, one cycle after the grant
//   nb_trans_o : granted-transaction counter, wraps at 2^32
// -----------------------------------------------------------------------------
module tcdm_slave_mem #(
  parameter int unsigned NB_PORTS   = 3,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_WORDS  = 1024,
  parameter logic [7:0]  STALL_SEED = 8'hA5
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NB_PORTS-1:0]                 req_i,
  output logic [NB_PORTS-1:0]                 gnt_o,
  input  logic [NB_PORTS-1:0][31:0]           add_i,
  input  logic [NB_PORTS-1:0]                 wen_i,
  input  logic [NB_PORTS-1:0][3:0]            be_i,
  input  logic [NB_PORTS-1:0][DATA_WIDTH-1:0] data_i,
  output logic [NB_PORTS-1:0][DATA_WIDTH-1:0] r_data_o,
  output logic [NB_PORTS-1:0]                 r_valid_o,
  output logic [31:0]                         nb_trans_o
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned PW = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PW-1:0]         r_rr_ptr;
  logic [31:0]           r_nb_trans;
  logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

  // ---------------------------------------------------------------------------
  // Arbitration and datapath wires
  // ---------------------------------------------------------------------------
  logic                  w_found;
  logic [PW-1:0]         w_winner;
  logic [31:0]           w_sum;
  logic [PW-1:0]         w_idx;
  logic                  w_stall;
  logic                  w_grant;

  logic [31:0]           w_add;
  logic                  w_wen;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_in_range;
  logic [AW-1:0]         w_word;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_unused;

  // ---------------------------------------------------------------------------
  // Optional stall generator
  // ---------------------------------------------------------------------------
`ifdef TCDM_SLAVE_STALL_EN
  logic [7:0] r_lfsr;
  logic       w_lfsr_fb;

  // The feedback comes from taps 8,6,5,4, which are bits 7,5,4,3. It shifts
  // in at bit 0, so bit 0 is the freshest pseudo-random bit.
  assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_stall   = r_lfsr[0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lfsr <= STALL_SEED;
    end else begin
      r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
    end
  end

  assign w_unused = ^w_add[1:0];
`else
  assign w_stall  = 1'b0;
  assign w_unused = ^{w_add[1:0], STALL_SEED};
`endif

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: the first requester at or above r_rr_ptr wins,
  // with the search wrapping modulo NB_PORTS.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_sum    = '0;
    w_idx    = '0;
    for (int unsigned i = 0; i < NB_PORTS; i++) begin
      w_sum = 32'(r_rr_ptr) + i;
      if (w_sum >= NB_PORTS) begin
        w_sum = w_sum - NB_PORTS;
      end
      w_idx = PW'(w_sum);
      if (!w_found && req_i[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  assign w_grant = w_found & ~w_stall;

  always_comb begin
    gnt_o = '0;
    if (w_grant) begin
      gnt_o[w_winner] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Winner's request fields and address decode
  // ---------------------------------------------------------------------------
  assign w_add   = add_i[w_winner];
  assign w_wen   = wen_i[w_winner];
  assign w_be    = be_i[w_winner];
  assign w_wdata = data_i[w_winner];

  assign w_in_range = (w_add[31:AW+2] == '0);
  assign w_word     = w_add[AW+1:2];

  // The read is synchronous at the grant edge. A write granted in the
  // previous cycle has therefore already landed in r_mem.
  assign w_rdata = (w_wen && w_in_range) ? r_mem[w_word] : '0;

  // ---------------------------------------------------------------------------
  // Memory write (contents are deliberately not reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_grant && !w_wen && w_in_range) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_word][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response, pointer and counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid_o  <= '0;
      r_data_o   <= '0;
      r_nb_trans <= '0;
      r_rr_ptr   <= '0;
    end else begin
      r_valid_o <= '0;
      if (w_grant) begin
        r_valid_o[w_winner] <= 1'b1;
        r_data_o[w_winner]  <= w_rdata;
        r_nb_trans          <= r_nb_trans + 32'd1;
        r_rr_ptr            <= (w_winner == PW'(NB_PORTS - 1)) ? '0 : w_winner + 1'b1;
      end
    end
  end

  assign nb_trans_o = r_nb_trans;

endmodule

// File: tb/tb_tcdm_slave_mem.sv
// -----------------------------------------------------------------------------
// tb_tcdm_slave_mem
//
// Directed bench for tcdm_slave_mem with default parameters (3 ports, 1024
// words). Expected values are hand-derived constants. With
// TCDM_SLAVE_STALL_EN defined, the stall section compares grants against a
// reference LFSR seeded with 8'hA5.
// -----------------------------------------------------------------------------
module tb_tcdm_slave_mem;

  logic              clk = 1'b0;
  logic              rst;
  logic [2:0]        req;
  logic [2:0]        gnt;
  logic [2:0][31:0]  add;
  logic [2:0]        wen;
  logic [2:0][3:0]   be;
  logic [2:0][31:0]  wdata;
  logic [2:0][31:0]  rdata;
  logic [2:0]        rvalid;
  logic [31:0]       nb;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_nb;

  tcdm_slave_mem #(
    .NB_PORTS   (3),
    .DATA_WIDTH (32),
    .MEM_WORDS  (1024),
    .STALL_SEED (8'hA5)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_i      (req),
    .gnt_o      (gnt),
    .add_i      (add),
    .wen_i      (wen),
    .be_i       (be),
    .data_i     (wdata),
    .r_data_o   (rdata),
    .r_valid_o  (rvalid),
    .nb_trans_o (nb)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_all();
    req   = '0;
    wen   = '1;
    add   = '0;
    be    = '0;
    wdata = '0;
  endtask

  task automatic set_port(input logic [1:0] p, input logic w, input logic [31:0] a,
                          input logic [3:0] b, input logic [31:0] d);
    req[p]   = 1'b1;
    wen[p]   = w;
    add[p]   = a;
    be[p]    = b;
    wdata[p] = d;
  endtask

  // Bounded wait for any grant. Without stalls, a grant is present
  // immediately and the loop body never runs.
  task automatic wait_gnt();
    for (int t = 0; t < 16 && gnt == 3'b000; t++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
    end
  endtask

  // One single-port transaction: grant check, then response and counter check.
  task automatic xact(input logic [1:0] p, input logic w, input logic [31:0] a,
                      input logic [3:0] b, input logic [31:0] d,
                      input logic [31:0] exp_rd, input string tag);
    @(negedge clk);
    clear_all();
    set_port(p, w, a, b, d);
    #1;
    wait_gnt();
    chk({tag, "/gnt"}, 64'(gnt), 64'(1) << p);
    @(posedge clk);
    #1;
    exp_nb = exp_nb + 32'd1;
    chk({tag, "/rvalid"}, 64'(rvalid), 64'(1) << p);
    chk({tag, "/rdata"},  64'(rdata[p]), 64'(exp_rd));
    chk({tag, "/nb"},     64'(nb), 64'(exp_nb));
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_all();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    exp_nb = '0;
  endtask

  logic [2:0][31:0] rot_add;
  logic [2:0][31:0] rot_exp;
  logic [1:0]       pk;
`ifdef TCDM_SLAVE_STALL_EN
  logic [7:0]       lf;
`endif
  logic             g;

  initial begin
    rst    = 1'b1;
    exp_nb = '0;
    clear_all();
    repeat (2) @(posedge clk);
    #1;
    chk("reset/rvalid", 64'(rvalid), 64'(0));
    for (int i = 0; i < 3; i++) begin
      chk("reset/rdata", 64'(rdata[i]), 64'(0));
    end
    chk("reset/nb", 64'(nb), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle/gnt", 64'(gnt), 64'(0));

    // Write, then back-to-back read of the same word on another port.
    xact(2'd0, 1'b0, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0,        "wr10");
    xact(2'd1, 1'b1, 32'h10, 4'h0, 32'h0,        32'hDEADBEEF, "rd10");

    // Partial write.
    xact(2'd2, 1'b0, 32'h20, 4'hF,    32'h12345678, 32'h0,        "wr20");
    xact(2'd2, 1'b0, 32'h20, 4'b0101, 32'hAABBCCDD, 32'h0,        "pwr20");
    xact(2'd0, 1'b1, 32'h20, 4'h0,    32'h0,        32'h12BB56DD, "rd20");
    // Bring rr_ptr back to 0 (last grant on port 2).
    xact(2'd2, 1'b1, 32'h10, 4'h0,    32'h0,        32'hDEADBEEF, "rd10b");

    // All three ports requesting continuously: grants go 0,1,2,0,1,2.
    rot_add = {32'h10, 32'h20, 32'h10};
    rot_exp = {32'hDEADBEEF, 32'h12BB56DD, 32'hDEADBEEF};
    @(negedge clk);
    clear_all();
    for (int p = 0; p < 3; p++) begin
      set_port(2'(p), 1'b1, rot_add[p], 4'h0, 32'h0);
    end
    #1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #1;
      end
      pk = 2'(k % 3);
      wait_gnt();
      chk("rot/gnt", 64'(gnt), 64'(1) << pk);
      @(posedge clk);
      #1;
      exp_nb = exp_nb + 32'd1;
      chk("rot/rvalid", 64'(rvalid), 64'(1) << pk);
      chk("rot/rdata",  64'(rdata[pk]), 64'(rot_exp[pk]));
    end
    @(negedge clk);
    clear_all();
    #1;
    chk("rot/nb", 64'(nb), 64'(exp_nb));

    // Lanes of ports that do not respond hold their last value.
    xact(2'd0, 1'b0, 32'h0, 4'hF, 32'h0BADF00D, 32'h0, "wr0");
    chk("hold/lane1", 64'(rdata[1]), 64'(32'h12BB56DD));
    chk("hold/lane2", 64'(rdata[2]), 64'(32'hDEADBEEF));

    // Out of range: the write is dropped, the read returns 0, and a
    // response is still issued.
    xact(2'd0, 1'b0, 32'h1000, 4'hF, 32'hFFFFFFFF, 32'h0,        "wroor");
    xact(2'd0, 1'b1, 32'h1000, 4'h0, 32'h0,        32'h0,        "rdoor");
    xact(2'd0, 1'b1, 32'h0,    4'h0, 32'h0,        32'h0BADF00D, "rd0");
    // Low address bits are ignored.
    xact(2'd1, 1'b1, 32'h13,   4'h0, 32'h0,        32'hDEADBEEF, "rd13");
    // A write with be=0 is a no-op.
    xact(2'd1, 1'b0, 32'h10,   4'h0, 32'h55555555, 32'h0,        "wrbe0");
    xact(2'd1, 1'b1, 32'h10,   4'h0, 32'h0,        32'hDEADBEEF, "rdbe0");

    // A write granted in the reset cycle is not performed, and its
    // response is suppressed.
    xact(2'd0, 1'b0, 32'h40, 4'hF, 32'h11112222, 32'h0, "wr40");
    @(negedge clk);
    clear_all();
    set_port(2'd0, 1'b0, 32'h40, 4'hF, 32'h99999999);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rstwr/rvalid", 64'(rvalid), 64'(0));
    chk("rstwr/nb",     64'(nb), 64'(0));
    @(negedge clk);
    clear_all();
    rst    = 1'b0;
    exp_nb = '0;
    xact(2'd1, 1'b1, 32'h40, 4'h0, 32'h0, 32'h11112222, "rstwr/rd40");

    // Counter wrap.
    @(negedge clk);
    clear_all();
    force dut.r_nb_trans = 32'hFFFFFFFF;
    #1;
    release dut.r_nb_trans;
    #1;
    chk("wrap/pre", 64'(nb), 64'(32'hFFFFFFFF));
    exp_nb = 32'hFFFFFFFF;
    xact(2'd2, 1'b1, 32'h20, 4'h0, 32'h0, 32'h12BB56DD, "wrap");

    // Continuous request on port 0 for 64 cycles after a fresh reset.
    do_reset();
    set_port(2'd0, 1'b1, 32'h10, 4'h0, 32'h0);
`ifdef TCDM_SLAVE_STALL_EN
    lf = 8'hA5;
`endif
    for (int c = 0; c < 64; c++) begin
      #1;
`ifdef TCDM_SLAVE_STALL_EN
      g = ~lf[0];
`else
      g = 1'b1;
`endif
      chk("stall/gnt", 64'(gnt), 64'(g));
      if (g) exp_nb = exp_nb + 32'd1;
      @(posedge clk);
`ifdef TCDM_SLAVE_STALL_EN
      lf = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
`endif
      @(negedge clk);
    end
    clear_all();
    #1;
    chk("stall/nb", 64'(nb), 64'(exp_nb));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
